// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the select lines through channels 0..3 with a
// programmable dwell, samples y_in at the end of each dwell and publishes a 4-bit frame.
module mux_scan_ctrl #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic       mode,
  output logic       s0,
  output logic       s1,
  input  logic       y_in,
  output logic [3:0] frame,
  output logic       valid,
  output logic       busy
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ch_q, ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    shadow_q, shadow_d;
  logic [3:0]    frame_q, frame_d;
  logic          valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= 2'd0;
      cnt_q    <= '0;
      shadow_q <= 3'd0;
      frame_q  <= 4'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ch_d  = 2'd0;
        cnt_d = '0;
        if (start && en) state_d = SCAN;
      end
      SCAN: begin
        if (!en) begin
          // Abort wins even on the final sample edge: no frame update, shadow dropped.
          state_d  = IDLE;
          ch_d     = 2'd0;
          cnt_d    = '0;
          shadow_d = 3'd0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (ch_q != 2'd3) begin
            for (int i = 0; i < 3; i++) begin
              if (ch_q == 2'(i)) shadow_d[i] = y_in;
            end
            ch_d = ch_q + 2'd1;
          end else begin
            frame_d = {y_in, shadow_q};
            valid_d = 1'b1;
            ch_d    = 2'd0;
            if (!mode) state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s0    = ch_q[0];
  assign s1    = ch_q[1];
  assign frame = frame_q;
  assign valid = valid_q;
  assign busy  = (state_q == SCAN);

endmodule
